float_round_pipe: RTL and testbench

Parametrised, pipelined successor to the single-precision round-to-nearest component. Rounds an IEEE-754-style float to an integral value, returned in the same float format. Adds a per-sample rounding mode, configurable exponent/mantissa widths, valid/ready flow control and an inexact flag. Sits in the math component library between float producers (adders, multipliers) and float-to-int converters.

---
 rtl/float_round_pipe_if.sv | 23 ++
 rtl/float_round_pipe.sv | 100 ++++++++++
 tb/tb_float_round_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/float_round_pipe_if.sv
// float_round_pipe_if: operand/result valid-ready streams of the float rounder.
interface float_round_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic [W-1:0] in_a;
  logic [1:0]   in_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_z;
  logic         out_inexact;
  logic         out_valid;
  logic         out_ready;
  modport master (
    output in_a, in_mode, in_valid, out_ready,
    input  in_ready, out_z, out_inexact, out_valid
  );
  modport slave (
    input  in_a, in_mode, in_valid, out_ready,
    output in_ready, out_z, out_inexact, out_valid
  );
endinterface

// File: rtl/float_round_pipe.sv
// float_round_pipe: two-stage float round-to-integral with per-sample mode and inexact flag.
module float_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  float_round_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int FB = BIAS + MAN_W;
  localparam logic [MAN_W-1:0] QBIT = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [MAN_W:0] ONE = {{MAN_W{1'b0}}, 1'b1};
  typedef enum logic [1:0] {K_PASS, K_SMALL, K_GEN} kind_t;
  logic             s1_valid_q;
  kind_t            s1_kind_q, s1_kind_d;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_man_q;
  logic [1:0]       s1_mode_q;
  logic [MAN_W:0]   s1_lsb_q, s1_lsb_d;
  logic [W-1:0]     s1_pass_q, s1_pass_d;
  logic             out_valid_q;
  logic [W-1:0]     out_z_q, out_z_d;
  logic             out_inexact_q, out_inexact_d;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic [31:0]      e32;
  logic             e_max, man_nz;
  logic             s2_en, s1_en;
  logic [MAN_W:0]   sig, frac, guard_m, kept, sum;
  logic             guard, sticky, lsb, inc, one, carry;
  assign {in_sign, in_exp, in_man} = io.in_a;
  assign s2_en = !out_valid_q | io.out_ready;
  assign s1_en = !s1_valid_q | s2_en;
  assign io.in_ready = s1_en;
  assign io.out_valid = out_valid_q;
  assign io.out_z = out_z_q;
  assign io.out_inexact = out_inexact_q;
  always_comb begin
    e32 = 32'(in_exp);
    e_max = &in_exp;
    man_nz = |in_man;
    s1_kind_d = (e_max || (e32 == 32'd0 && !man_nz) || e32 >= 32'(FB)) ? K_PASS :
                (e32 < 32'(BIAS)) ? K_SMALL : K_GEN;
    s1_pass_d = {in_sign, in_exp, in_man | ((e_max && man_nz) ? QBIT : {MAN_W{1'b0}})};
    s1_lsb_d = ONE << (32'(FB) - e32);
  end
  always_comb begin
    sig = {1'b1, s1_man_q};
    frac = s1_lsb_q - ONE;
    guard_m = s1_lsb_q >> 1;
    guard = |(sig & guard_m);
    sticky = |(sig & frac & ~guard_m);
    lsb = |(sig & s1_lsb_q);
    kept = sig & ~frac;
    inc = (s1_mode_q == 2'd0) ? guard & (sticky | lsb) :
          (s1_mode_q == 2'd1) ? 1'b0 :
          (s1_mode_q == 2'd2) ? !s1_sign_q & (guard | sticky) :
                                 s1_sign_q & (guard | sticky);
    sum = kept + (inc ? s1_lsb_q : {(MAN_W+1){1'b0}});
    // sum is at least 2^MAN_W, so a cleared top bit can only mean it wrapped to 2^(MAN_W+1)
    carry = !sum[MAN_W];
    one = (s1_mode_q == 2'd0) ? (s1_exp_q == EXP_W'(BIAS - 1)) && (|s1_man_q) :
          (s1_mode_q == 2'd1) ? 1'b0 :
          (s1_mode_q == 2'd2) ? !s1_sign_q : s1_sign_q;
    out_z_d = (s1_kind_q == K_PASS) ? s1_pass_q :
              (s1_kind_q == K_SMALL) ? {s1_sign_q, one ? EXP_W'(BIAS) : {EXP_W{1'b0}}, {MAN_W{1'b0}}} :
              {s1_sign_q, s1_exp_q + {{(EXP_W-1){1'b0}}, carry}, sum[MAN_W-1:0]};
    out_inexact_d = (s1_kind_q == K_SMALL) || (s1_kind_q == K_GEN && (guard || sticky));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= io.in_valid;
        s1_kind_q <= s1_kind_d;
        s1_sign_q <= in_sign;
        s1_exp_q <= in_exp;
        s1_man_q <= in_man;
        s1_mode_q <= io.in_mode;
        s1_lsb_q <= s1_lsb_d;
        s1_pass_q <= s1_pass_d;
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_z_q <= out_z_d;
          out_inexact_q <= out_inexact_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_float_round_pipe.sv
// tb_float_round_pipe: directed scoreboard bench for single and half precision rounding.
module tb_float_round_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  float_round_pipe_if #(.EXP_W(8), .MAN_W(23)) s();
  float_round_pipe_if #(.EXP_W(5), .MAN_W(10)) h();
  float_round_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .io(s.slave));
  float_round_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .io(h.slave));
  int tests = 0;
  int fails = 0;
  logic [32:0] q_s[$];
  logic [16:0] q_h[$];
  logic [32:0] nxt_s;
  logic [16:0] nxt_h;
  logic acc_s, acc_h;
  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [32:0] es;
    logic [16:0] eh;
    @(negedge clk);
    acc_s = 1'b0;
    acc_h = 1'b0;
    if (!rst) begin
      if (s.in_valid && s.in_ready) begin q_s.push_back(nxt_s); acc_s = 1'b1; end
      if (h.in_valid && h.in_ready) begin q_h.push_back(nxt_h); acc_h = 1'b1; end
      if (s.out_valid && s.out_ready) begin
        if (q_s.size() == 0) chk("spurious_s", 33'(q_s.size()), 33'd1);
        else begin
          es = q_s.pop_front();
          chk("z_s", 33'(s.out_z), 33'(es[31:0]));
          chk("inexact_s", 33'(s.out_inexact), 33'(es[32]));
        end
      end
      if (h.out_valid && h.out_ready) begin
        if (q_h.size() == 0) chk("spurious_h", 33'(q_h.size()), 33'd1);
        else begin
          eh = q_h.pop_front();
          chk("z_h", 33'(h.out_z), 33'(eh[15:0]));
          chk("inexact_h", 33'(h.out_inexact), 33'(eh[16]));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send_s(input logic [31:0] a, input logic [1:0] m, input logic [31:0] z, input logic x);
    s.in_a = a;
    s.in_mode = m;
    s.in_valid = 1'b1;
    nxt_s = {x, z};
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_s) break;
    end
    if (!acc_s) chk("accept_timeout_s", 33'(acc_s), 33'd1);
  endtask
  task automatic send_h(input logic [15:0] a, input logic [1:0] m, input logic [15:0] z, input logic x);
    h.in_a = a;
    h.in_mode = m;
    h.in_valid = 1'b1;
    nxt_h = {x, z};
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_h) break;
    end
    if (!acc_h) chk("accept_timeout_h", 33'(acc_h), 33'd1);
  endtask
  task automatic idle(input int n);
    s.in_valid = 1'b0;
    h.in_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    rst = 1'b1;
    s.in_a = '0; s.in_mode = 2'd0; s.in_valid = 1'b0; s.out_ready = 1'b1;
    h.in_a = '0; h.in_mode = 2'd0; h.in_valid = 1'b0; h.out_ready = 1'b1;
    nxt_s = '0; nxt_h = '0;
    tick();
    tick();
    chk("rst_out_valid", 33'(s.out_valid), 33'd0);
    chk("rst_out_z", 33'(s.out_z), 33'd0);
    chk("rst_inexact", 33'(s.out_inexact), 33'd0);
    chk("rst_in_ready", 33'(s.in_ready), 33'd1);
    rst = 1'b0;
    // RNE stream: the first result must be present in the cycle after the second accept
    send_s(32'h40200000, 2'd0, 32'h40000000, 1'b1);
    chk("lat_not_yet", 33'(s.out_valid), 33'd0);
    send_s(32'h40600000, 2'd0, 32'h40800000, 1'b1);
    chk("lat_valid", 33'(s.out_valid), 33'd1);
    send_s(32'h3FC00000, 2'd0, 32'h40000000, 1'b1);
    chk("tput_valid1", 33'(s.out_valid), 33'd1);
    send_s(32'h3F000000, 2'd0, 32'h00000000, 1'b1);
    chk("tput_valid2", 33'(s.out_valid), 33'd1);
    send_s(32'hC0200000, 2'd1, 32'hC0000000, 1'b1);
    send_s(32'hC0200000, 2'd2, 32'hC0000000, 1'b1);
    send_s(32'hC0200000, 2'd3, 32'hC0400000, 1'b1);
    send_s(32'h3E99999A, 2'd2, 32'h3F800000, 1'b1);
    send_s(32'hBFD9999A, 2'd1, 32'hBF800000, 1'b1);
    send_s(32'hBE99999A, 2'd2, 32'h80000000, 1'b1);
    send_s(32'hBE99999A, 2'd3, 32'hBF800000, 1'b1);
    send_s(32'h3F000001, 2'd0, 32'h3F800000, 1'b1);
    send_s(32'h7F800001, 2'd0, 32'h7FC00001, 1'b0);
    send_s(32'hFF800000, 2'd0, 32'hFF800000, 1'b0);
    send_s(32'h80000000, 2'd0, 32'h80000000, 1'b0);
    send_s(32'h00000001, 2'd2, 32'h3F800000, 1'b1);
    send_s(32'h4B000001, 2'd0, 32'h4B000001, 1'b0);
    send_s(32'h3FFFFFFF, 2'd0, 32'h40000000, 1'b1);
    send_s(32'h3FA00000, 2'd0, 32'h3F800000, 1'b1);
    idle(4);
    chk("drain_basic", 33'(q_s.size()), 33'd0);
    // backpressure: only two samples fit while the output is stalled
    s.out_ready = 1'b0;
    send_s(32'h40200000, 2'd0, 32'h40000000, 1'b1);
    send_s(32'h40600000, 2'd0, 32'h40800000, 1'b1);
    s.in_a = 32'h3FC00000;
    s.in_mode = 2'd0;
    s.in_valid = 1'b1;
    nxt_s = {1'b1, 32'h40000000};
    repeat (3) begin
      tick();
      chk("bp_no_accept", 33'(acc_s), 33'd0);
      chk("bp_in_ready", 33'(s.in_ready), 33'd0);
      chk("bp_hold_z", 33'(s.out_z), 33'h040000000);
      chk("bp_hold_valid", 33'(s.out_valid), 33'd1);
    end
    s.out_ready = 1'b1;
    send_s(32'h3FC00000, 2'd0, 32'h40000000, 1'b1);
    send_s(32'hC0200000, 2'd0, 32'hC0000000, 1'b1);
    idle(5);
    chk("drain_bp", 33'(q_s.size()), 33'd0);
    // reset with both stages full discards the in-flight samples
    s.out_ready = 1'b0;
    send_s(32'h3FC00000, 2'd0, 32'h40000000, 1'b1);
    send_s(32'h40200000, 2'd0, 32'h40000000, 1'b1);
    chk("full_in_ready", 33'(s.in_ready), 33'd0);
    s.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_s.delete();
    chk("mid_rst_out_valid", 33'(s.out_valid), 33'd0);
    chk("mid_rst_out_z", 33'(s.out_z), 33'd0);
    chk("mid_rst_in_ready", 33'(s.in_ready), 33'd1);
    s.out_ready = 1'b1;
    idle(4);
    send_s(32'h40600000, 2'd0, 32'h40800000, 1'b1);
    idle(4);
    chk("drain_rst", 33'(q_s.size()), 33'd0);
    send_h(16'h4100, 2'd0, 16'h4000, 1'b1);
    send_h(16'h4300, 2'd0, 16'h4400, 1'b1);
    send_h(16'h7C01, 2'd0, 16'h7E01, 1'b0);
    send_h(16'hC100, 2'd3, 16'hC200, 1'b1);
    idle(4);
    chk("drain_h", 33'(q_h.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
